// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM encoding, transfer limits and the
// message-type constants understood by the SPI slave.
package spi_pkg;

   localparam int DATA_W    = 48;
   localparam int MAX_BYTES = 6;
   localparam int BIT_CNT_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_XFER     = 3'd2,
      ST_CS_HOLD  = 3'd3,
      ST_GAP      = 3'd4
   } spi_state_t;

   // Slave message types; the low nibble is the payload length in bytes.
   localparam logic [7:0] MSG_RECV    = 8'h00;
   localparam logic [7:0] MSG_SEND_2B = 8'h12;
   localparam logic [7:0] MSG_SEND_6B = 8'h16;

   function automatic int msg_bits(input logic [7:0] msg);
      return 8 * int'(msg[3:0]);
   endfunction

   // Byte count to bit count, with 7 clamped to the 6-byte maximum.
   function automatic logic [BIT_CNT_W-1:0] bits_for(input logic [2:0] nb);
      logic [2:0] nb_c;
      nb_c = (nb > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : nb;
      return {nb_c, 3'b000};
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period divider: counts CLK_DIV cycles per half period while run is
// high and marks each half-period end as a rise or fall strobe.
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic run,
   output logic tick,
   output logic rise_stb,
   output logic fall_stb
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] half_cnt;
   logic       phase;

   assign tick     = run && (half_cnt == LAST);
   assign rise_stb = tick && !phase;
   assign fall_stb = tick &&  phase;

   // Phase restarts at 0 each time run rises, so the first strobe is a rise.
   always_ff @(posedge CLK) begin
      if (RST || !run) begin
         half_cnt <= 8'd0;
         phase    <= 1'b0;
      end else if (tick) begin
         half_cnt <= 8'd0;
         phase    <= ~phase;
      end else begin
         half_cnt <= half_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 style framing: MOSI changes on SCK rise, MISO sampled on
// SCK fall, 1..6 bytes MSB first, with CSEL setup/hold and inter-frame gap.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [2:0]        num_bytes,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              SCK,
   output logic              MOSI,
   output logic              CSEL,
   input  logic              MISO,
   output spi_state_t        fsm_state
);

   spi_state_t           state, state_nxt;
   logic [DATA_W-1:0]    tx_reg, tx_nxt, rx_nxt;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_nxt;
   logic [15:0]          gap_cnt, gap_nxt;
   logic                 sck_nxt, mosi_nxt, csel_nxt, done_nxt;
   logic                 div_run, tick, rise_stb, fall_stb;

   assign div_run   = (state == ST_CS_SETUP) || (state == ST_XFER) || (state == ST_CS_HOLD);
   assign busy      = (state != ST_IDLE);
   assign fsm_state = state;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .CLK      (CLK),
      .RST      (RST),
      .run      (div_run),
      .tick     (tick),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         tx_reg  <= '0;
         rx_data <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         SCK     <= 1'b0;
         MOSI    <= 1'b0;
         CSEL    <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         tx_reg  <= tx_nxt;
         rx_data <= rx_nxt;
         bit_cnt <= bit_nxt;
         gap_cnt <= gap_nxt;
         SCK     <= sck_nxt;
         MOSI    <= mosi_nxt;
         CSEL    <= csel_nxt;
         done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tx_nxt    = tx_reg;
      rx_nxt    = rx_data;
      bit_nxt   = bit_cnt;
      gap_nxt   = gap_cnt;
      sck_nxt   = SCK;
      mosi_nxt  = MOSI;
      csel_nxt  = CSEL;
      done_nxt  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            sck_nxt  = 1'b0;
            mosi_nxt = 1'b0;
            csel_nxt = 1'b1;
            if (start && (num_bytes != 3'd0)) begin
               tx_nxt    = tx_data;
               rx_nxt    = '0;
               bit_nxt   = bits_for(num_bytes);
               csel_nxt  = 1'b0;
               state_nxt = ST_CS_SETUP;
            end
         end
         ST_CS_SETUP: begin
            if (tick) begin
               sck_nxt   = 1'b1;
               mosi_nxt  = tx_reg[bit_cnt - 6'd1];
               bit_nxt   = bit_cnt - 6'd1;
               state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            // bit_cnt counts bits not yet launched; zero at a rise means the
            // last bit's low phase has just completed.
            if (fall_stb) begin
               sck_nxt = 1'b0;
               rx_nxt  = {rx_data[DATA_W-2:0], MISO};
            end else if (rise_stb) begin
               if (bit_cnt == '0) begin
                  state_nxt = ST_CS_HOLD;
               end else begin
                  sck_nxt  = 1'b1;
                  mosi_nxt = tx_reg[bit_cnt - 6'd1];
                  bit_nxt  = bit_cnt - 6'd1;
               end
            end
         end
         ST_CS_HOLD: begin
            if (tick) begin
               csel_nxt  = 1'b1;
               mosi_nxt  = 1'b0;
               done_nxt  = 1'b1;
               gap_nxt   = '0;
               state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt == 16'(CS_GAP - 1)) begin
               gap_nxt   = '0;
               state_nxt = ST_IDLE;
            end else begin
               gap_nxt = gap_cnt + 16'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (CLK_DIV 4 and 17) sharing a
// small SPI slave model that can receive, send a message, or tie MISO high.
module tb_spi_master;
   import spi_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [2:0]  num_bytes = 3'd0;
   logic [47:0] tx_data = '0;
   logic        miso;

   logic        busy_a, done_a, sck_a, mosi_a, csel_a;
   logic        busy_b, done_b, sck_b, mosi_b, csel_b;
   logic [47:0] rx_a, rx_b;
   spi_state_t  st_a, st_b;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   spi_master #(.CLK_DIV(4), .CS_GAP(8)) dut_a (
      .CLK(CLK), .RST(RST), .start(start_a), .num_bytes(num_bytes), .tx_data(tx_data),
      .busy(busy_a), .done(done_a), .rx_data(rx_a), .SCK(sck_a), .MOSI(mosi_a),
      .CSEL(csel_a), .MISO(miso), .fsm_state(st_a)
   );

   spi_master #(.CLK_DIV(17), .CS_GAP(8)) dut_b (
      .CLK(CLK), .RST(RST), .start(start_b), .num_bytes(num_bytes), .tx_data(tx_data),
      .busy(busy_b), .done(done_b), .rx_data(rx_b), .SCK(sck_b), .MOSI(mosi_b),
      .CSEL(csel_b), .MISO(miso), .fsm_state(st_b)
   );

   // Observed instance selector
   logic        use_b = 1'b0;
   logic        m_sck, m_mosi, m_csel, m_busy, m_done;
   logic [47:0] m_rx;
   assign m_sck  = use_b ? sck_b  : sck_a;
   assign m_mosi = use_b ? mosi_b : mosi_a;
   assign m_csel = use_b ? csel_b : csel_a;
   assign m_busy = use_b ? busy_b : busy_a;
   assign m_done = use_b ? done_b : done_a;
   assign m_rx   = use_b ? rx_b   : rx_a;

   // SPI slave model
   logic        tie_high = 1'b0;
   logic        slave_send = 1'b0;
   logic [7:0]  slave_msg = MSG_RECV;
   logic [47:0] slave_out = '0;
   logic [47:0] slave_rx = '0;
   logic        slave_miso = 1'b0;
   int          slave_idx = 0;

   assign miso = tie_high ? 1'b1 : (slave_send ? slave_miso : 1'b0);

   always @(negedge m_csel or posedge m_sck) begin
      if (m_sck) begin
         if (slave_idx >= 0) slave_miso = slave_out[slave_idx];
         slave_idx = slave_idx - 1;
      end else begin
         slave_idx = msg_bits(slave_msg) - 1;
      end
   end

   always @(negedge m_sck) slave_rx = {slave_rx[46:0], m_mosi};

   // Per-transfer measurements
   int          r_pulses, r_csel_low, r_done_cnt, r_phase_err, r_mosi_err;
   logic        r_timeout, r_first_busy;
   logic [47:0] r_rx_at_done, r_rx_end;

   // Called at a negedge; starts a transfer on the selected instance and
   // samples every cycle until busy drops. inj_cyc >= 0 pulses a second start.
   task automatic run_xfer(input logic [2:0] nb, input logic [47:0] tx, input int inj_cyc);
      logic p_sck, p_mosi, p_csel, in_low;
      int   hi_len, lo_len, cd;
      cd = use_b ? 17 : 4;
      r_pulses = 0; r_csel_low = 0; r_done_cnt = 0; r_phase_err = 0; r_mosi_err = 0;
      r_timeout = 1'b1; r_first_busy = 1'b0; r_rx_at_done = '0; r_rx_end = '0;
      hi_len = 0; lo_len = 0; in_low = 1'b0; p_sck = 1'b0; p_mosi = 1'b0; p_csel = 1'b1;
      num_bytes = nb;
      tx_data   = tx;
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge CLK);
      start_a = 1'b0;
      start_b = 1'b0;
      r_first_busy = m_busy;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!m_csel) r_csel_low++;
         if (m_done) begin
            r_done_cnt++;
            r_rx_at_done = m_rx;
         end
         if (m_sck && !p_sck) begin
            r_pulses++;
            if (in_low && lo_len != cd) r_phase_err++;
            in_low = 1'b0;
            hi_len = 1;
         end else if (m_sck) begin
            hi_len++;
         end
         if (!m_sck && p_sck) begin
            if (hi_len != cd) r_phase_err++;
            in_low = 1'b1;
            lo_len = 1;
         end else if (!m_sck && in_low) begin
            lo_len++;
         end
         if (!m_csel && !p_csel && (m_mosi != p_mosi) && !(m_sck && !p_sck)) r_mosi_err++;
         p_sck = m_sck; p_mosi = m_mosi; p_csel = m_csel;
         if (!m_busy) begin
            r_timeout = 1'b0;
            r_rx_end  = m_rx;
            break;
         end
         if (cyc == inj_cyc) begin
            num_bytes = 3'd6;
            tx_data   = '1;
            if (use_b) start_b = 1'b1; else start_a = 1'b1;
         end
         @(negedge CLK);
         start_a = 1'b0;
         start_b = 1'b0;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge CLK);
      start_a = 1'b1; num_bytes = 3'd2; tx_data = 48'hA55A;
      @(negedge CLK);
      total++; if (sck_a !== 1'b0)   begin bad++; $display("FAIL rst_sck: got %b want 0", sck_a); end
      total++; if (mosi_a !== 1'b0)  begin bad++; $display("FAIL rst_mosi: got %b want 0", mosi_a); end
      total++; if (csel_a !== 1'b1)  begin bad++; $display("FAIL rst_csel: got %b want 1", csel_a); end
      total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
      total++; if (done_a !== 1'b0)  begin bad++; $display("FAIL rst_done: got %b want 0", done_a); end
      total++; if (rx_a !== 48'h0)   begin bad++; $display("FAIL rst_rx: got %h want 0", rx_a); end
      total++; if (st_a !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", st_a, ST_IDLE); end
      RST = 1'b0; start_a = 1'b0;
      @(negedge CLK);
      total++; if (busy_a !== 1'b0 || csel_a !== 1'b1) begin bad++; $display("FAIL rst_start_ignored: busy=%b csel=%b want 0/1", busy_a, csel_a); end
   endtask

   task automatic test_recv;
      slave_send = 1'b0; slave_msg = MSG_RECV; tie_high = 1'b0;
      run_xfer(3'd2, 48'h0000_0000_A55A, -1);
      total++; if (r_timeout !== 1'b0)       begin bad++; $display("FAIL recv_timeout: busy never fell"); end
      total++; if (slave_rx[15:0] !== 16'hA55A) begin bad++; $display("FAIL recv_data: got %h want a55a", slave_rx[15:0]); end
      total++; if (r_pulses != 16)           begin bad++; $display("FAIL recv_pulses: got %0d want 16", r_pulses); end
      total++; if (r_done_cnt != 1)          begin bad++; $display("FAIL recv_done: got %0d want 1", r_done_cnt); end
      total++; if (r_csel_low != 136)        begin bad++; $display("FAIL recv_csel_low: got %0d want 136", r_csel_low); end
      total++; if (r_phase_err != 0)         begin bad++; $display("FAIL recv_phase: got %0d bad phases want 0", r_phase_err); end
      total++; if (r_mosi_err != 0)          begin bad++; $display("FAIL recv_mosi_edge: got %0d stray changes want 0", r_mosi_err); end
      total++; if (r_rx_at_done !== 48'h0)   begin bad++; $display("FAIL recv_rx: got %h want 0", r_rx_at_done); end
   endtask

   task automatic test_send6;
      slave_send = 1'b1; slave_msg = MSG_SEND_6B; slave_out = 48'h1234_5678_9ABC; tie_high = 1'b0;
      run_xfer(3'd6, 48'h0F0F_0F0F_0F0F, -1);
      total++; if (r_rx_at_done !== 48'h1234_5678_9ABC) begin bad++; $display("FAIL send6_rx: got %h want 123456789abc", r_rx_at_done); end
      total++; if (r_rx_end !== 48'h1234_5678_9ABC)     begin bad++; $display("FAIL send6_rx_hold: got %h want 123456789abc", r_rx_end); end
      total++; if (r_pulses != 48)    begin bad++; $display("FAIL send6_pulses: got %0d want 48", r_pulses); end
      total++; if (r_csel_low != 392) begin bad++; $display("FAIL send6_csel_low: got %0d want 392", r_csel_low); end
      total++; if (slave_rx !== 48'h0F0F_0F0F_0F0F) begin bad++; $display("FAIL send6_mosi: got %h want 0f0f0f0f0f0f", slave_rx); end
      slave_send = 1'b0; slave_msg = MSG_RECV;
   endtask

   task automatic test_tie_high;
      tie_high = 1'b1;
      run_xfer(3'd1, 48'h0000_0000_0081, -1);
      total++; if (r_rx_at_done !== 48'h0000_0000_00FF) begin bad++; $display("FAIL tie1_rx: got %h want ff", r_rx_at_done); end
      total++; if (r_pulses != 8) begin bad++; $display("FAIL tie1_pulses: got %0d want 8", r_pulses); end
      run_xfer(3'd7, 48'h0, -1);
      total++; if (r_rx_at_done !== 48'hFFFF_FFFF_FFFF) begin bad++; $display("FAIL clamp7_rx: got %h want ffffffffffff", r_rx_at_done); end
      total++; if (r_pulses != 48) begin bad++; $display("FAIL clamp7_pulses: got %0d want 48", r_pulses); end
      tie_high = 1'b0;
   endtask

   task automatic test_zero_bytes;
      int seen_busy, seen_csel;
      seen_busy = 0; seen_csel = 0;
      num_bytes = 3'd0; tx_data = 48'hFF; start_a = 1'b1;
      @(negedge CLK);
      start_a = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy_a) seen_busy++;
         if (!csel_a) seen_csel++;
         @(negedge CLK);
      end
      total++; if (seen_busy != 0) begin bad++; $display("FAIL zero_busy: got %0d busy cycles want 0", seen_busy); end
      total++; if (seen_csel != 0) begin bad++; $display("FAIL zero_csel: got %0d low cycles want 0", seen_csel); end
   endtask

   task automatic test_back_to_back;
      slave_send = 1'b0; tie_high = 1'b0;
      run_xfer(3'd2, 48'h0000_0000_A55A, 40);
      total++; if (slave_rx[15:0] !== 16'hA55A) begin bad++; $display("FAIL busy_ign_data: got %h want a55a", slave_rx[15:0]); end
      total++; if (r_pulses != 16)  begin bad++; $display("FAIL busy_ign_pulses: got %0d want 16", r_pulses); end
      total++; if (r_done_cnt != 1) begin bad++; $display("FAIL busy_ign_done: got %0d want 1", r_done_cnt); end
      total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL busy_ign_timeout: busy never fell"); end
      run_xfer(3'd1, 48'h0000_0000_003C, -1);
      total++; if (r_first_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy %b want 1", r_first_busy); end
      total++; if (slave_rx[7:0] !== 8'h3C) begin bad++; $display("FAIL b2b_data: got %h want 3c", slave_rx[7:0]); end
   endtask

   task automatic test_reset_mid;
      logic p;
      int   rises;
      tie_high = 1'b1; rises = 0; p = 1'b0;
      num_bytes = 3'd3; tx_data = 48'h00C3_5A96; start_a = 1'b1;
      @(negedge CLK);
      start_a = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (sck_a && !p) rises++;
         p = sck_a;
         if (rises == 9) break;
         @(negedge CLK);
      end
      total++; if (rises != 9) begin bad++; $display("FAIL mid_reach_bit9: got %0d rises want 9", rises); end
      RST = 1'b1;
      @(negedge CLK);
      total++; if (csel_a !== 1'b1) begin bad++; $display("FAIL mid_csel: got %b want 1", csel_a); end
      total++; if (sck_a !== 1'b0)  begin bad++; $display("FAIL mid_sck: got %b want 0", sck_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy_a); end
      total++; if (rx_a !== 48'h0)  begin bad++; $display("FAIL mid_rx: got %h want 0", rx_a); end
      RST = 1'b0; tie_high = 1'b0;
      run_xfer(3'd3, 48'h0000_00AB_CDEF, -1);
      total++; if (slave_rx[23:0] !== 24'hABCDEF) begin bad++; $display("FAIL mid_clean_data: got %h want abcdef", slave_rx[23:0]); end
      total++; if (r_pulses != 24)  begin bad++; $display("FAIL mid_clean_pulses: got %0d want 24", r_pulses); end
      total++; if (r_done_cnt != 1) begin bad++; $display("FAIL mid_clean_done: got %0d want 1", r_done_cnt); end
   endtask

   task automatic test_div17;
      use_b = 1'b1; slave_send = 1'b0; tie_high = 1'b0;
      run_xfer(3'd1, 48'h0000_0000_0096, -1);
      total++; if (slave_rx[7:0] !== 8'h96) begin bad++; $display("FAIL div17_data: got %h want 96", slave_rx[7:0]); end
      total++; if (r_pulses != 8)     begin bad++; $display("FAIL div17_pulses: got %0d want 8", r_pulses); end
      total++; if (r_phase_err != 0)  begin bad++; $display("FAIL div17_phase: got %0d bad phases want 0", r_phase_err); end
      total++; if (r_mosi_err != 0)   begin bad++; $display("FAIL div17_mosi_edge: got %0d stray changes want 0", r_mosi_err); end
      total++; if (r_csel_low != 306) begin bad++; $display("FAIL div17_csel_low: got %0d want 306", r_csel_low); end
      total++; if (r_done_cnt != 1)   begin bad++; $display("FAIL div17_done: got %0d want 1", r_done_cnt); end
      use_b = 1'b0;
   endtask

   initial begin
      test_reset;
      test_recv;
      test_send6;
      test_tie_high;
      test_zero_bytes;
      test_back_to_back;
      test_reset_mid;
      test_div17;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning CLK cycles per SCK half-period; legal range 4..255.
REQ-002 SHALL have parameter CS_GAP, default 8, meaning minimum CLK cycles CSEL stays high between transfers.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle transfer request, sampled only in IDLE.
REQ-006 SHALL have port num_bytes  input  3  bytes to transfer (1..6), captured with start.
REQ-007 SHALL have port tx_data  input  48  outgoing data, right-justified, captured with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of transfer.
REQ-010 SHALL have port rx_data  output  48  received data, right-justified, valid when done.
REQ-011 SHALL have port SCK  output  1  serial clock, idles low.
REQ-012 SHALL have port MOSI  output  1  serial data out, MSB first.
REQ-013 SHALL have port CSEL  output  1  chip select, active low.
REQ-014 SHALL have port MISO  input  1  serial data in, sampled without synchroniser (the slave drives it from the same CLK domain).

Function
REQ-015 SHALL implement states IDLE, CS_SETUP, XFER, CS_HOLD, GAP.
REQ-016 IDLE: start with num_bytes in 1..6 SHALL capture tx_data, load bit counter = 8*num_bytes, clear rx_data, and enter CS_SETUP; CSEL goes low on the same edge.
REQ-017 start with num_bytes = 0 SHALL be ignored; num_bytes 7 SHALL be clamped to 6.
REQ-018 start while busy SHALL be ignored with no effect on the current transfer.
REQ-019 CS_SETUP SHALL last CLK_DIV cycles with SCK low, then enter XFER.
REQ-020 XFER: each bit SHALL take 2*CLK_DIV cycles: SCK rises at bit start, falls after CLK_DIV cycles.
REQ-021 MOSI SHALL update to the next bit (tx bit 8*num_bytes-1 down to 0) on the same edge SCK rises and hold until the next rise.
REQ-022 MISO SHALL be shifted into rx_data LSB on the edge SCK falls; rx_data SHALL hold the partial value during transfer.
REQ-023 After the falling edge of the last bit, SHALL enter CS_HOLD for CLK_DIV cycles with CSEL low, SCK low.
REQ-024 CS_HOLD end SHALL raise CSEL, pulse done for one cycle, and enter GAP.
REQ-025 GAP SHALL hold CSEL high for CS_GAP cycles; busy stays high; then return to IDLE with busy low.
REQ-026 Outside CS_SETUP..CS_HOLD, SHALL drive SCK = 0, MOSI = 0, CSEL = 1.
REQ-027 Bit counter SHALL be 6 bits; half-period counter SHALL be 8 bits and wrap to 0 at CLK_DIV-1.
REQ-028 rx_data SHALL remain stable after done until the next accepted start.

Reset
REQ-029 RST SHALL force IDLE on the next CLK edge, including mid-transfer: SCK=0, MOSI=0, CSEL=1, busy=0, done=0, rx_data=0, all counters 0.
REQ-030 A start asserted in the same cycle as RST SHALL be ignored.

Structure
REQ-031 State encodings, the 6-byte maximum, and the 48-bit data width SHALL live in the shared SPI package alongside the slave's message-type constants.
REQ-032 The SCK half-period divider SHALL be one sub-module named spi_clk_div, emitting rise/fall strobes; all else stays in spi_master.

Verification
REQ-033 Transfer tx_data=0x0000_0000_A55A, num_bytes=2, to the SPI slave model in receive mode -> 16 SCK pulses; slave receives 0xA55A; done pulses once; CSEL low for 2*CLK_DIV*16+2*CLK_DIV cycles.
REQ-034 Slave in send mode with 6-byte type and output 0x1234_5678_9ABC, num_bytes=6 -> rx_data=0x1234_5678_9ABC at done.
REQ-035 num_bytes=1, MISO tied high -> rx_data=0x0000_0000_00FF; num_bytes=0 -> busy never rises, CSEL stays high.
REQ-036 Second start pulsed during XFER -> ignored; first transfer completes unchanged; a start in the cycle after busy falls is accepted.
REQ-037 RST asserted at bit 9 of a 3-byte transfer -> next cycle CSEL=1, SCK=0, busy=0; following start runs a clean transfer.
REQ-038 CLK_DIV=4 and CLK_DIV=17 runs -> SCK high/low phases measure exactly CLK_DIV cycles each; MOSI changes only on SCK rise.
